// File: rtl/operand_bypass_stage_pkg.sv
// Shared widths and forwarding-stage indices for the operand bypass stage.
package operand_bypass_stage_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int N_SRC_DEF     = 2;
  localparam int PAYLOAD_W_DEF = 136;

  // Forwarding sources are ordered youngest first: EXE, then MEM, then WB.
  localparam int FWD_EXE = 0;
  localparam int FWD_MEM = FWD_EXE + 1;
  localparam int FWD_WB  = FWD_MEM + 1;

  localparam int N_FWD_DEF = FWD_WB + 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/operand_bypass_stage_bypass_select.sv
// Per-source bypass selection: finds the youngest forwarding stage that
// writes this source register and muxes its result over the register file.
module bypass_select
  import operand_bypass_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_FWD  = N_FWD_DEF
) (
  input  logic [ADDR_W-1:0]       raddr,
  input  logic                    ruse,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic [N_FWD*ADDR_W-1:0] fwd_dest,
  input  logic [N_FWD-1:0]        fwd_ready,
  input  logic [N_FWD*DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic [DATA_W-1:0]       operand,
  output logic                    hazard
);

  logic              hit;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_data;

  // Scan oldest to youngest so the youngest match is the one left standing;
  // r0 never matches since it is hard-wired to zero.
  always_comb begin
    hit       = 1'b0;
    sel_ready = 1'b1;
    sel_data  = '0;
    for (int k = N_FWD - 1; k >= FWD_EXE; k--) begin
      if (ruse && (raddr != '0) && fwd_valid[k] && fwd_we[k] &&
          (fwd_dest[k*ADDR_W +: ADDR_W] == raddr)) begin
        hit       = 1'b1;
        sel_ready = fwd_ready[k];
        sel_data  = fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Final operand value and hazard flag; a pending result in the chosen
  // stage blocks even if an older stage has the value ready.
  always_comb begin
    operand = rf_rdata;
    hazard  = hit && !sel_ready;
    if (raddr == '0) begin
      operand = '0;
    end else if (hit) begin
      operand = sel_data;
    end
  end

endmodule

// File: rtl/operand_bypass_stage.sv
// Pipeline stage that holds one decoded instruction, resolves its source
// operands through the forwarding network and stalls on pending results.
module operand_bypass_stage
  import operand_bypass_stage_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int N_SRC     = N_SRC_DEF,
  parameter int N_FWD     = N_FWD_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_allowin,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic [N_SRC*ADDR_W-1:0] in_raddr,
  input  logic [N_SRC-1:0]        in_ruse,
  output logic [N_SRC*ADDR_W-1:0] rf_raddr,
  input  logic [N_SRC*DATA_W-1:0] rf_rdata,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic [N_FWD*ADDR_W-1:0] fwd_dest,
  input  logic [N_FWD-1:0]        fwd_ready,
  input  logic [N_FWD*DATA_W-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_allowin,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [N_SRC*DATA_W-1:0] out_operand,
  output logic [31:0]             stall_cnt
);

  logic                    valid;
  logic [PAYLOAD_W-1:0]    payload_q;
  logic [N_SRC*ADDR_W-1:0] raddr_q;
  logic [N_SRC-1:0]        ruse_q;
  logic [N_SRC-1:0]        hazard;
  logic                    ready_go;

  // One selector per source operand.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    bypass_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N_FWD  (N_FWD)
    ) u_bypass_select (
      .raddr     (raddr_q[i*ADDR_W +: ADDR_W]),
      .ruse      (ruse_q[i]),
      .fwd_valid (fwd_valid),
      .fwd_we    (fwd_we),
      .fwd_dest  (fwd_dest),
      .fwd_ready (fwd_ready),
      .fwd_data  (fwd_data),
      .rf_rdata  (rf_rdata[i*DATA_W +: DATA_W]),
      .operand   (out_operand[i*DATA_W +: DATA_W]),
      .hazard    (hazard[i])
    );
  end

  // Handshake: the stage can move on once no source waits on a pending result.
  always_comb begin
    ready_go   = ~|hazard;
    in_allowin = !valid || (ready_go && out_allowin);
    out_valid  = valid && ready_go && !flush;
  end

  assign rf_raddr    = raddr_q;
  assign out_payload = payload_q;

  // Occupancy flag; a flush wins over any incoming instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (in_allowin) begin
      valid <= in_valid;
    end
  end

  // Capture the instruction on acceptance; loading during a flush is
  // harmless because valid stays low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      payload_q <= '0;
      raddr_q   <= '0;
      ruse_q    <= '0;
    end else if (in_valid && in_allowin) begin
      payload_q <= in_payload;
      raddr_q   <= in_raddr;
      ruse_q    <= in_ruse;
    end
  end

  // Count cycles lost to hazards, ignoring cycles being flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (valid && !ready_go && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_operand_bypass_stage.sv
// Directed self-checking bench for operand_bypass_stage.
module tb_operand_bypass_stage;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int N_SRC     = 2;
  localparam int N_FWD     = 3;
  localparam int PAYLOAD_W = 136;

  logic                    clk;
  logic                    resetn;
  logic                    in_valid;
  logic                    in_allowin;
  logic [PAYLOAD_W-1:0]    in_payload;
  logic [N_SRC*ADDR_W-1:0] in_raddr;
  logic [N_SRC-1:0]        in_ruse;
  logic [N_SRC*ADDR_W-1:0] rf_raddr;
  logic [N_SRC*DATA_W-1:0] rf_rdata;
  logic [N_FWD-1:0]        fwd_valid;
  logic [N_FWD-1:0]        fwd_we;
  logic [N_FWD*ADDR_W-1:0] fwd_dest;
  logic [N_FWD-1:0]        fwd_ready;
  logic [N_FWD*DATA_W-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_allowin;
  logic [PAYLOAD_W-1:0]    out_payload;
  logic [N_SRC*DATA_W-1:0] out_operand;
  logic [31:0]             stall_cnt;

  int tests_run;
  int tests_failed;

  operand_bypass_stage #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .N_SRC     (N_SRC),
    .N_FWD     (N_FWD),
    .PAYLOAD_W (PAYLOAD_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_payload  (in_payload),
    .in_raddr    (in_raddr),
    .in_ruse     (in_ruse),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .fwd_valid   (fwd_valid),
    .fwd_we      (fwd_we),
    .fwd_dest    (fwd_dest),
    .fwd_ready   (fwd_ready),
    .fwd_data    (fwd_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_allowin (out_allowin),
    .out_payload (out_payload),
    .out_operand (out_operand),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid    = 1'b0;
    in_payload  = '0;
    in_raddr    = '0;
    in_ruse     = '0;
    rf_rdata    = '0;
    fwd_valid   = '0;
    fwd_we      = '0;
    fwd_dest    = '0;
    fwd_ready   = '0;
    fwd_data    = '0;
    flush       = 1'b0;
    out_allowin = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    #1;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [ADDR_W-1:0] dest,
                         input logic ready, input logic [DATA_W-1:0] data);
    fwd_valid[k]                  = 1'b1;
    fwd_we[k]                     = we;
    fwd_dest[k*ADDR_W +: ADDR_W]  = dest;
    fwd_ready[k]                  = ready;
    fwd_data[k*DATA_W +: DATA_W]  = data;
  endtask

  task automatic accept(input logic [PAYLOAD_W-1:0] p, input logic [ADDR_W-1:0] r0,
                        input logic [ADDR_W-1:0] r1, input logic [1:0] ruse);
    in_valid   = 1'b1;
    in_payload = p;
    in_raddr   = {r1, r0};
    in_ruse    = ruse;
    step();
    in_valid   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
    end
    tests_run++;
    if (in_allowin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_allowin got %0b want 1", in_allowin);
    end
    tests_run++;
    if (stall_cnt !== 32'd0 || rf_raddr !== '0 || out_payload !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs got cnt=%0d raddr=%h payload=%h want 0", stall_cnt, rf_raddr, out_payload);
    end
  endtask

  task automatic test_exe_forward();
    logic [PAYLOAD_W-1:0] p;
    p = {8'hC3, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF};
    do_reset();
    accept(p, 5'd8, 5'd3, 2'b11);
    rf_rdata = {32'h0000_3333, 32'h0000_AAAA};
    set_fwd(0, 1'b1, 5'd8, 1'b1, 32'h0000_1234);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_operand[31:0] !== 32'h0000_1234) begin
      tests_failed++;
      $display("[TB] FAIL exe_fwd got valid=%0b op0=%h want 1 00001234", out_valid, out_operand[31:0]);
    end
    tests_run++;
    if (out_operand[63:32] !== 32'h0000_3333) begin
      tests_failed++;
      $display("[TB] FAIL rf_fallback got %h want 00003333", out_operand[63:32]);
    end
    tests_run++;
    if (rf_raddr !== {5'd3, 5'd8} || out_payload !== p) begin
      tests_failed++;
      $display("[TB] FAIL captured_regs got raddr=%h payload=%h want %h %h", rf_raddr, out_payload, {5'd3, 5'd8}, p);
    end
    // MEM and WB also write r3; the younger MEM value must win.
    set_fwd(1, 1'b1, 5'd3, 1'b1, 32'h0000_5555);
    set_fwd(2, 1'b1, 5'd3, 1'b1, 32'h0000_6666);
    #1;
    tests_run++;
    if (out_operand[63:32] !== 32'h0000_5555) begin
      tests_failed++;
      $display("[TB] FAIL mem_priority got %h want 00005555", out_operand[63:32]);
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    accept('0, 5'd8, 5'd0, 2'b01);
    set_fwd(0, 1'b1, 5'd8, 1'b0, 32'h0);
    set_fwd(1, 1'b1, 5'd8, 1'b1, 32'h0000_7777);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_stall got valid=%0b allowin=%0b want 0 0", out_valid, in_allowin);
    end
    step();
    set_fwd(0, 1'b1, 5'd8, 1'b1, 32'h0000_BEEF);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_operand[31:0] !== 32'h0000_BEEF || stall_cnt !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL load_resolve got valid=%0b op0=%h cnt=%0d want 1 0000beef 1", out_valid, out_operand[31:0], stall_cnt);
    end
  endtask

  task automatic test_r0_source();
    do_reset();
    accept('0, 5'd0, 5'd0, 2'b11);
    rf_rdata = {32'hDEAD_0001, 32'hDEAD_0000};
    for (int k = 0; k < N_FWD; k++) set_fwd(k, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_operand !== '0) begin
      tests_failed++;
      $display("[TB] FAIL r0_source got valid=%0b ops=%h want 1 0", out_valid, out_operand);
    end
  endtask

  task automatic test_unused_source();
    do_reset();
    accept('0, 5'd4, 5'd9, 2'b01);
    rf_rdata = {32'h0000_0909, 32'h0000_0404};
    set_fwd(0, 1'b1, 5'd9, 1'b0, 32'h0000_00EE);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_operand[63:32] !== 32'h0000_0909) begin
      tests_failed++;
      $display("[TB] FAIL unused_source got valid=%0b op1=%h want 1 00000909", out_valid, out_operand[63:32]);
    end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    accept('0, 5'd8, 5'd0, 2'b01);
    set_fwd(0, 1'b1, 5'd8, 1'b0, 32'h0);
    step();
    step();
    step();
    tests_run++;
    if (stall_cnt !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL stall_count got %0d want 3", stall_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_allowin !== 1'b1 || stall_cnt !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL flush_hazard got valid=%0b allowin=%0b cnt=%0d want 0 1 3", out_valid, in_allowin, stall_cnt);
    end
    // Flush coinciding with a new instruction drops it as well.
    fwd_valid = '0;
    in_valid  = 1'b1;
    in_raddr  = {5'd0, 5'd2};
    in_ruse   = 2'b01;
    flush     = 1'b1;
    step();
    in_valid  = 1'b0;
    flush     = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_with_in got valid=%0b allowin=%0b want 0 1", out_valid, in_allowin);
    end
  endtask

  task automatic test_back_to_back();
    logic [PAYLOAD_W-1:0] p;
    logic [PAYLOAD_W-1:0] q;
    p = {8'h11, 128'h0};
    q = {8'h22, 128'h5};
    do_reset();
    accept(p, 5'd1, 5'd2, 2'b11);
    out_allowin = 1'b0;
    in_valid    = 1'b1;
    in_payload  = q;
    in_raddr    = {5'd6, 5'd5};
    in_ruse     = 2'b11;
    #1;
    tests_run++;
    if (in_allowin !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure got allowin=%0b valid=%0b want 0 1", in_allowin, out_valid);
    end
    step();
    step();
    tests_run++;
    if (out_payload !== p || rf_raddr !== {5'd2, 5'd1} || stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL payload_held got payload=%h raddr=%h cnt=%0d want %h %h 0", out_payload, rf_raddr, stall_cnt, p, {5'd2, 5'd1});
    end
    out_allowin = 1'b1;
    #1;
    tests_run++;
    if (in_allowin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_allowin got %0b want 1", in_allowin);
    end
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_payload !== q || out_valid !== 1'b1 || rf_raddr !== {5'd6, 5'd5}) begin
      tests_failed++;
      $display("[TB] FAIL next_instr got payload=%h valid=%0b raddr=%h want %h 1 %h", out_payload, out_valid, rf_raddr, q, {5'd6, 5'd5});
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    accept('0, 5'd8, 5'd0, 2'b01);
    set_fwd(0, 1'b1, 5'd8, 1'b0, 32'h0);
    step();
    step();
    tests_run++;
    if (stall_cnt !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_count got %0d want 2", stall_cnt);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || stall_cnt !== 32'd0 || in_allowin !== 1'b1 || rf_raddr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_stall got valid=%0b cnt=%0d allowin=%0b raddr=%h want 0 0 1 0", out_valid, stall_cnt, in_allowin, rf_raddr);
    end
    step();
    resetn = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL resume_empty got valid=%0b cnt=%0d want 0 0", out_valid, stall_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    clear_inputs();
    test_reset();
    test_exe_forward();
    test_load_stall();
    test_r0_source();
    test_unused_source();
    test_flush_hazard();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_bypass_stage.md
OPERAND_BYPASS_STAGE -- requirements
Module: operand_bypass_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-number width.
REQ-003 SHALL have parameter N_SRC, default 2, source operands per instruction.
REQ-004 SHALL have parameter N_FWD, default 3, forwarding sources; index 0 is youngest (EXE), then MEM, then WB.
REQ-005 SHALL have parameter PAYLOAD_W, default 136, opaque decoded-instruction bits carried through.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Ports, in this order:
clk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
in_valid  in  1  upstream holds an instruction.
in_allowin  out  1  stage accepts upstream this cycle.
in_payload  in  PAYLOAD_W  decoded instruction bits.
in_raddr  in  N_SRC*ADDR_W  source register numbers.
in_ruse  in  N_SRC  source i is actually read.
rf_raddr  out  N_SRC*ADDR_W  registered source numbers to register file.
rf_rdata  in  N_SRC*DATA_W  combinational register-file read data.
fwd_valid  in  N_FWD  forwarding stage holds a valid instruction.
fwd_we  in  N_FWD  that instruction writes a register.
fwd_dest  in  N_FWD*ADDR_W  its destination.
fwd_ready  in  N_FWD  its result is available now (0 = load pending).
fwd_data  in  N_FWD*DATA_W  its result.
flush  in  1  discard held instruction.
out_valid  out  1  stage presents a hazard-free instruction.
out_allowin  in  1  downstream accepts.
out_payload  out  PAYLOAD_W  registered payload.
out_operand  out  N_SRC*DATA_W  resolved operand values.
stall_cnt  out  32  cycles spent stalled on hazards.

Function
REQ-008 SHALL register in_payload, in_raddr, in_ruse when in_valid && in_allowin; rf_raddr and out_payload come from these registers.
REQ-009 SHALL update valid each cycle: flush -> 0; else if in_allowin -> in_valid; else hold.
REQ-010 SHALL drive in_allowin = !valid || (ready_go && out_allowin); out_valid = valid && ready_go && !flush.
REQ-011 Match for source i at stage k: in_ruse[i] && raddr[i]!=0 && fwd_valid[k] && fwd_we[k] && fwd_dest[k]==raddr[i].
REQ-012 SHALL select, per source, the lowest-index matching stage only; older matches are ignored.
REQ-013 SHALL flag hazard for source i when its selected stage has fwd_ready=0; ready_go = no source hazards.
REQ-014 out_operand[i] SHALL be: 0 if raddr[i]==0; else fwd_data of the selected stage if any; else rf_rdata[i].
REQ-015 Operand resolution SHALL be combinational (zero added latency); the stage has one-cycle latency from acceptance to out_valid if no hazard.
REQ-016 stall_cnt SHALL increment by 1 each cycle valid && !ready_go && !flush, saturating at 0xFFFF_FFFF.
REQ-017 Flush with in_valid in the same cycle SHALL drop both; payload registers may load but valid stays 0.
REQ-018 Unused sources (in_ruse=0) SHALL never cause a stall.

Reset
REQ-019 On resetn low: valid=0, stall_cnt=0, payload/raddr/ruse registers=0; hence out_valid=0, in_allowin=1, rf_raddr=0.
REQ-020 Reset deassertion mid-stall SHALL resume from empty; no instruction survives reset.

Structure
REQ-021 Default widths and the stage-index constants SHALL live in the shared mycpu header/package beside the bus-width macros.
REQ-022 One sub-module, bypass_select (one instance per source), SHALL perform the priority match and data mux of REQ-011..014.

Verification
REQ-023 Source r8 read, EXE writes r8, ready=1, data 0x1234 -> out_operand[0]=0x1234, out_valid same cycle.
REQ-024 EXE load to r8 (ready=0), MEM also writes r8 ready -> stall; next cycle EXE ready with 0xBEEF -> operand 0xBEEF, stall_cnt=1.
REQ-025 Source r0, all stages write r0 with ready=0 -> no stall, operand 0.
REQ-026 Hazard held 3 cycles then flush -> valid 0 next cycle, stall_cnt=3, in_allowin=1.
REQ-027 out_allowin=0 for 2 cycles with no hazard -> payload held, in_allowin=0, stall_cnt unchanged.
REQ-028 resetn asserted while stalled -> out_valid=0, stall_cnt=0 immediately.
